// File: rtl/psram_arb_pkg.sv
// rtl/psram_arb_pkg.sv - shared types, constants and helpers for the PSRAM bus arbiter
// Purpose: FSM state encoding, chip-select bit positions within the byte address,
//          and chip-index extraction helper.
// Ports:   none (package).
package psram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    GAP   = 2'd3
  } state_t;

  localparam int PKG_ADDR_WIDTH = 25;
  localparam int CS_IDX_MSB     = 24;
  localparam int CS_IDX_LSB     = 23;

  // Upper two address bits select one of the four 8 MB devices.
  function automatic logic [1:0] cs_idx(input logic [PKG_ADDR_WIDTH-1:0] addr);
    return addr[CS_IDX_MSB:CS_IDX_LSB];
  endfunction

endpackage

// File: rtl/psram_bus_arbiter_if.sv
// rtl/psram_bus_arbiter_if.sv - requester and PHY signal bundle for the PSRAM bus arbiter
// Purpose: groups the per-requester request/response lines and the PHY command
//          lines. Signal suffixes (_i/_o) are from the arbiter's point of view.
// Modports: slave  - the arbiter (consumes requests, drives the PHY command)
//           master - the environment (requesters and PHY)
interface psram_bus_arbiter_if #(
  parameter int NUM_REQ    = 3,
  parameter int ADDR_WIDTH = 25,
  parameter int DATA_WIDTH = 32
);
  logic [NUM_REQ-1:0]              req_valid_i;
  logic [NUM_REQ-1:0]              req_ready_o;
  logic [NUM_REQ-1:0]              req_we_i;
  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr_i;
  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata_i;
  logic [NUM_REQ*DATA_WIDTH/8-1:0] req_wstrb_i;
  logic [NUM_REQ-1:0]              rsp_valid_o;
  logic                            rsp_err_o;
  logic [DATA_WIDTH-1:0]           rsp_rdata_o;
  logic                            phy_valid_o;
  logic                            phy_ready_i;
  logic [1:0]                      phy_cs_o;
  logic [ADDR_WIDTH-3:0]           phy_addr_o;
  logic                            phy_we_o;
  logic [DATA_WIDTH-1:0]           phy_wdata_o;
  logic [DATA_WIDTH/8-1:0]         phy_wstrb_o;
  logic                            phy_done_i;
  logic [DATA_WIDTH-1:0]           phy_rdata_i;
  logic                            phy_abort_o;

  modport slave (
    input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_wstrb_i,
    input  phy_ready_i, phy_done_i, phy_rdata_i,
    output req_ready_o, rsp_valid_o, rsp_err_o, rsp_rdata_o,
    output phy_valid_o, phy_cs_o, phy_addr_o, phy_we_o, phy_wdata_o, phy_wstrb_o, phy_abort_o
  );

  modport master (
    output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_wstrb_i,
    output phy_ready_i, phy_done_i, phy_rdata_i,
    input  req_ready_o, rsp_valid_o, rsp_err_o, rsp_rdata_o,
    input  phy_valid_o, phy_cs_o, phy_addr_o, phy_we_o, phy_wdata_o, phy_wstrb_o, phy_abort_o
  );
endinterface

// File: rtl/psram_rr_arb.sv
// rtl/psram_rr_arb.sv - combinational round-robin picker
// Purpose: selects the first asserted request at or after the pointer, wrapping
//          modulo NUM_REQ.
// Ports:   i_req   request vector
//          i_ptr   highest-priority index
//          o_grant one-hot winner (zero when no request)
//          o_idx   winner index
//          o_any   at least one request present
module psram_rr_arb #(
  parameter int NUM_REQ = 3,
  parameter int PW      = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PW-1:0]      i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [PW-1:0]      o_idx,
  output logic               o_any
);
  int            w_sum;
  logic [PW-1:0] w_k;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_sum   = 0;
    w_k     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_sum = int'(i_ptr) + i;
      if (w_sum >= NUM_REQ) w_sum = w_sum - NUM_REQ;
      w_k = PW'(w_sum);
      if (!o_any && i_req[w_k]) begin
        o_any      = 1'b1;
        o_grant[w_k] = 1'b1;
        o_idx      = w_k;
      end
    end
  end
endmodule

// File: rtl/psram_bus_arbiter.sv
// rtl/psram_bus_arbiter.sv - round-robin arbiter sharing one quad-SPI PSRAM PHY
// Purpose: grants one requester at a time, latches its command, drives the PHY,
//          returns the completion to the owner, aborts hung transactions and
//          enforces an NSS-high gap between transactions.
// Ports:   clk_i  system clock
//          rst_i  asynchronous active-high reset
//          bus    requester/PHY bundle (slave view)
module psram_bus_arbiter
  import psram_arb_pkg::*;
#(
  parameter int NUM_REQ     = 3,
  parameter int ADDR_WIDTH  = 25,
  parameter int DATA_WIDTH  = 32,
  parameter int CS_GAP_CYC  = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input logic                clk_i,
  input logic                rst_i,
  psram_bus_arbiter_if.slave bus
);
  localparam int PW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW       = $clog2(TIMEOUT_CYC);
  localparam int GW       = (CS_GAP_CYC > 1) ? $clog2(CS_GAP_CYC) : 1;
  localparam int GAP_LAST = (CS_GAP_CYC > 0) ? CS_GAP_CYC - 1 : 0;
  localparam int SW       = DATA_WIDTH / 8;
  localparam state_t ST_AFTER_RSP = (CS_GAP_CYC > 0) ? GAP : IDLE;

  state_t                r_state, w_next;
  logic [PW-1:0]         r_ptr;
  logic [NUM_REQ-1:0]    r_owner_oh;
  logic [TW-1:0]         r_tmo;
  logic [GW-1:0]         r_gap;
  logic [1:0]            r_cs;
  logic [ADDR_WIDTH-3:0] r_addr;
  logic                  r_we;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [SW-1:0]         r_wstrb;
  logic [NUM_REQ-1:0]    r_rsp_valid;
  logic                  r_rsp_err;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;

  logic [NUM_REQ-1:0]    w_grant;
  logic [PW-1:0]         w_idx;
  logic                  w_any, w_accept, w_done, w_timeout, w_gap_end;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic                  w_we;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [SW-1:0]         w_wstrb;

  psram_rr_arb #(.NUM_REQ(NUM_REQ), .PW(PW)) u_rr_arb (
    .i_req   (bus.req_valid_i),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  assign w_accept  = (r_state == IDLE) && w_any;
  assign w_done    = (r_state == WAIT) && bus.phy_done_i;
  // A done arriving on the last allowed cycle still completes normally.
  assign w_timeout = ((r_state == ISSUE) || (r_state == WAIT)) && !w_done &&
                     (r_tmo == TW'(TIMEOUT_CYC - 1));
  assign w_gap_end = (r_gap == GW'(GAP_LAST));

  // Winner's payload, selected with constant slices by the one-hot grant.
  always_comb begin
    w_addr  = '0;
    w_we    = 1'b0;
    w_wdata = '0;
    w_wstrb = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_addr  = bus.req_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_we    = bus.req_we_i[i];
        w_wdata = bus.req_wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
        w_wstrb = bus.req_wstrb_i[i*SW +: SW];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next          = r_state;
    // Ready is masked during reset so a held request is never seen as accepted.
    bus.req_ready_o = ((r_state == IDLE) && !rst_i) ? w_grant : '0;
    bus.phy_valid_o = (r_state == ISSUE) && !w_timeout;
    bus.phy_abort_o = w_timeout;
    case (r_state)
      IDLE:    if (w_any) w_next = ISSUE;
      ISSUE:   if (w_timeout) w_next = ST_AFTER_RSP;
               else if (bus.phy_ready_i) w_next = WAIT;
      WAIT:    if (w_done || w_timeout) w_next = ST_AFTER_RSP;
      GAP:     if (w_gap_end) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ptr       <= '0;
      r_owner_oh  <= '0;
      r_tmo       <= '0;
      r_gap       <= '0;
      r_cs        <= '0;
      r_addr      <= '0;
      r_we        <= 1'b0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_rsp_valid <= '0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      if (w_accept) begin
        r_ptr      <= (w_idx == PW'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
        r_owner_oh <= w_grant;
        r_cs       <= cs_idx(w_addr);
        r_addr     <= w_addr[ADDR_WIDTH-3:0];
        r_we       <= w_we;
        r_wdata    <= w_wdata;
        r_wstrb    <= w_wstrb;
      end

      if (w_accept) r_tmo <= '0;
      else if ((r_state == ISSUE) || (r_state == WAIT)) r_tmo <= r_tmo + 1'b1;

      if (r_state == GAP) r_gap <= r_gap + 1'b1;
      else                r_gap <= '0;

      // Error and data hold between responses; only the valid pulse clears.
      r_rsp_valid <= '0;
      if (w_done) begin
        r_rsp_valid <= r_owner_oh;
        r_rsp_err   <= 1'b0;
        r_rsp_rdata <= r_we ? '0 : bus.phy_rdata_i;
      end else if (w_timeout) begin
        r_rsp_valid <= r_owner_oh;
        r_rsp_err   <= 1'b1;
        r_rsp_rdata <= '0;
      end
    end
  end

  assign bus.phy_cs_o    = r_cs;
  assign bus.phy_addr_o  = r_addr;
  assign bus.phy_we_o    = r_we;
  assign bus.phy_wdata_o = r_wdata;
  assign bus.phy_wstrb_o = r_wstrb;
  assign bus.rsp_valid_o = r_rsp_valid;
  assign bus.rsp_err_o   = r_rsp_err;
  assign bus.rsp_rdata_o = r_rsp_rdata;
endmodule

// File: tb/tb_psram_bus_arbiter.sv
// tb/tb_psram_bus_arbiter.sv - self-checking bench for psram_bus_arbiter
module tb_psram_bus_arbiter;
  logic clk;
  logic rst;
  int   n_assert = 0;
  int   n_fail   = 0;

  typedef struct {
    logic [2:0]  valid;
    logic        rdy;
    logic        done;
    logic [31:0] rdata;
    logic [2:0]  e_ready;
    logic        e_pv;
    logic [1:0]  e_cs;
    logic [22:0] e_addr;
    logic [2:0]  e_rsp;
    logic        e_err;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t tv [16];

  psram_bus_arbiter_if #(.NUM_REQ(3), .ADDR_WIDTH(25), .DATA_WIDTH(32)) bus ();

  psram_bus_arbiter #(
    .NUM_REQ(3), .ADDR_WIDTH(25), .DATA_WIDTH(32), .CS_GAP_CYC(2), .TIMEOUT_CYC(16)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Bounded wait for a grant, then compare the one-hot ready vector.
  task automatic expect_grant(input string name, input logic [2:0] exp);
    int n;
    n = 0;
    #1;
    while (bus.req_ready_o == 3'b000 && n < 8) begin
      tick();
      #1;
      n++;
    end
    chk(name, 32'(bus.req_ready_o), 32'(exp));
  endtask

  initial begin
    //           valid  rdy   done  rdata          ready  pv    cs    addr     rsp    err   rdata
    tv[0]  = '{3'b111, 1'b0, 1'b1, 32'h0,        3'b001, 1'b0, 2'd0, 23'h00, 3'b000, 1'b0, 32'h0};
    tv[1]  = '{3'b111, 1'b1, 1'b0, 32'h0,        3'b000, 1'b1, 2'd1, 23'h10, 3'b000, 1'b0, 32'h0};
    tv[2]  = '{3'b111, 1'b0, 1'b1, 32'h11111111, 3'b000, 1'b0, 2'd0, 23'h00, 3'b000, 1'b0, 32'h0};
    tv[3]  = '{3'b111, 1'b1, 1'b0, 32'h0,        3'b000, 1'b0, 2'd0, 23'h00, 3'b001, 1'b0, 32'h11111111};
    tv[4]  = '{3'b111, 1'b0, 1'b0, 32'h0,        3'b000, 1'b0, 2'd0, 23'h00, 3'b000, 1'b0, 32'h0};
    tv[5]  = '{3'b111, 1'b0, 1'b0, 32'h0,        3'b010, 1'b0, 2'd0, 23'h00, 3'b000, 1'b0, 32'h0};
    tv[6]  = '{3'b111, 1'b1, 1'b0, 32'h0,        3'b000, 1'b1, 2'd2, 23'h20, 3'b000, 1'b0, 32'h0};
    tv[7]  = '{3'b111, 1'b0, 1'b1, 32'h22222222, 3'b000, 1'b0, 2'd0, 23'h00, 3'b000, 1'b0, 32'h0};
    tv[8]  = '{3'b111, 1'b0, 1'b0, 32'h0,        3'b000, 1'b0, 2'd0, 23'h00, 3'b010, 1'b0, 32'h0};
    tv[9]  = '{3'b111, 1'b0, 1'b0, 32'h0,        3'b000, 1'b0, 2'd0, 23'h00, 3'b000, 1'b0, 32'h0};
    tv[10] = '{3'b111, 1'b0, 1'b0, 32'h0,        3'b100, 1'b0, 2'd0, 23'h00, 3'b000, 1'b0, 32'h0};
    tv[11] = '{3'b111, 1'b0, 1'b1, 32'h0BADBAD0, 3'b000, 1'b1, 2'd3, 23'h30, 3'b000, 1'b0, 32'h0};
    tv[12] = '{3'b111, 1'b1, 1'b0, 32'h0,        3'b000, 1'b1, 2'd3, 23'h30, 3'b000, 1'b0, 32'h0};
    tv[13] = '{3'b111, 1'b0, 1'b1, 32'h33333333, 3'b000, 1'b0, 2'd0, 23'h00, 3'b000, 1'b0, 32'h0};
    tv[14] = '{3'b111, 1'b0, 1'b0, 32'h0,        3'b000, 1'b0, 2'd0, 23'h00, 3'b100, 1'b0, 32'h33333333};
    tv[15] = '{3'b111, 1'b0, 1'b0, 32'h0,        3'b000, 1'b0, 2'd0, 23'h00, 3'b000, 1'b0, 32'h0};

    rst             = 1'b1;
    bus.req_valid_i = 3'b000;
    bus.req_we_i    = 3'b010;
    bus.req_addr_i  = {25'h1800030, 25'h1000020, 25'h0800010};
    bus.req_wdata_i = {32'hC2C2C2C2, 32'hB1B1B1B1, 32'hA0A0A0A0};
    bus.req_wstrb_i = {4'hF, 4'h3, 4'hF};
    bus.phy_ready_i = 1'b0;
    bus.phy_done_i  = 1'b0;
    bus.phy_rdata_i = 32'h0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("reset ready", 32'(bus.req_ready_o), 32'h0);
    chk("reset phy_valid", 32'(bus.phy_valid_o), 32'h0);
    chk("reset abort", 32'(bus.phy_abort_o), 32'h0);
    chk("reset rsp_valid", 32'(bus.rsp_valid_o), 32'h0);
    chk("reset rsp_err", 32'(bus.rsp_err_o), 32'h0);
    chk("reset rsp_rdata", bus.rsp_rdata_o, 32'h0);
    chk("reset phy_cs", 32'(bus.phy_cs_o), 32'h0);
    tick();

    // All three requesters continuously valid: grants 0,1,2 with gap and ignored strobes
    for (int i = 0; i < 16; i++) begin
      bus.req_valid_i = tv[i].valid;
      bus.phy_ready_i = tv[i].rdy;
      bus.phy_done_i  = tv[i].done;
      bus.phy_rdata_i = tv[i].rdata;
      #1;
      chk($sformatf("v%0d ready", i), 32'(bus.req_ready_o), 32'(tv[i].e_ready));
      chk($sformatf("v%0d phy_valid", i), 32'(bus.phy_valid_o), 32'(tv[i].e_pv));
      chk($sformatf("v%0d rsp_valid", i), 32'(bus.rsp_valid_o), 32'(tv[i].e_rsp));
      chk($sformatf("v%0d abort", i), 32'(bus.phy_abort_o), 32'h0);
      if (tv[i].e_pv) begin
        chk($sformatf("v%0d phy_cs", i), 32'(bus.phy_cs_o), 32'(tv[i].e_cs));
        chk($sformatf("v%0d phy_addr", i), 32'(bus.phy_addr_o), 32'(tv[i].e_addr));
      end
      if (tv[i].e_rsp != 3'b000) begin
        chk($sformatf("v%0d rsp_err", i), 32'(bus.rsp_err_o), 32'(tv[i].e_err));
        chk($sformatf("v%0d rsp_rdata", i), bus.rsp_rdata_o, tv[i].e_rdata);
      end
      tick();
    end
    bus.phy_ready_i = 1'b0;
    bus.phy_done_i  = 1'b0;

    // Second round of the rotation
    for (int r = 0; r < 3; r++) begin
      bus.req_valid_i = 3'b111;
      expect_grant($sformatf("rr2 grant %0d", r), 3'(1 << r));
      tick();
      bus.phy_ready_i = 1'b1;
      #1;
      chk($sformatf("rr2 phy_valid %0d", r), 32'(bus.phy_valid_o), 32'h1);
      tick();
      bus.phy_ready_i = 1'b0;
      bus.phy_done_i  = 1'b1;
      bus.phy_rdata_i = 32'h100 + 32'(r);
      tick();
      bus.phy_done_i  = 1'b0;
      #1;
      chk($sformatf("rr2 rsp_valid %0d", r), 32'(bus.rsp_valid_o), 32'(1 << r));
      chk($sformatf("rr2 rsp_rdata %0d", r), bus.rsp_rdata_o, (r == 1) ? 32'h0 : 32'h100 + 32'(r));
      tick();
      tick();
    end

    // Single read from requester 0
    bus.req_valid_i = 3'b001;
    expect_grant("t1 grant", 3'b001);
    tick();
    bus.req_valid_i = 3'b000;
    bus.phy_ready_i = 1'b1;
    #1;
    chk("t1 phy_valid", 32'(bus.phy_valid_o), 32'h1);
    chk("t1 phy_cs", 32'(bus.phy_cs_o), 32'h1);
    chk("t1 phy_addr", 32'(bus.phy_addr_o), 32'h000010);
    tick();
    bus.phy_ready_i = 1'b0;
    bus.phy_done_i  = 1'b1;
    bus.phy_rdata_i = 32'hDEADBEEF;
    #1;
    chk("t1 wait phy_valid", 32'(bus.phy_valid_o), 32'h0);
    tick();
    bus.phy_done_i  = 1'b0;
    bus.phy_rdata_i = 32'h0;
    #1;
    chk("t1 rsp_valid", 32'(bus.rsp_valid_o), 32'h1);
    chk("t1 rsp_rdata", bus.rsp_rdata_o, 32'hDEADBEEF);
    chk("t1 rsp_err", 32'(bus.rsp_err_o), 32'h0);
    tick();
    chk("t1 rsp pulse", 32'(bus.rsp_valid_o), 32'h0);
    chk("t1 rdata hold", bus.rsp_rdata_o, 32'hDEADBEEF);
    tick();

    // Back-pressure: phy_ready low for 5 cycles
    bus.req_valid_i = 3'b001;
    expect_grant("t3 grant", 3'b001);
    tick();
    bus.req_valid_i = 3'b000;
    for (int h = 0; h < 5; h++) begin
      #1;
      chk($sformatf("t3 phy_valid c%0d", h), 32'(bus.phy_valid_o), 32'h1);
      chk($sformatf("t3 phy_addr c%0d", h), 32'(bus.phy_addr_o), 32'h000010);
      chk($sformatf("t3 phy_wdata c%0d", h), bus.phy_wdata_o, 32'hA0A0A0A0);
      tick();
    end
    bus.phy_ready_i = 1'b1;
    #1;
    chk("t3 phy_valid accept", 32'(bus.phy_valid_o), 32'h1);
    tick();
    bus.phy_ready_i = 1'b0;
    #1;
    chk("t3 single command", 32'(bus.phy_valid_o), 32'h0);
    bus.phy_done_i  = 1'b1;
    bus.phy_rdata_i = 32'h5A5A5A5A;
    tick();
    bus.phy_done_i  = 1'b0;
    #1;
    chk("t3 rsp_valid", 32'(bus.rsp_valid_o), 32'h1);
    chk("t3 rsp_rdata", bus.rsp_rdata_o, 32'h5A5A5A5A);
    tick();
    tick();

    // Timeout on requester 1 while requester 0 waits
    bus.req_valid_i = 3'b011;
    expect_grant("t4 grant", 3'b010);
    tick();
    bus.req_valid_i = 3'b001;
    bus.phy_ready_i = 1'b1;
    for (int c = 0; c < 16; c++) begin
      #1;
      chk($sformatf("t4 abort c%0d", c), 32'(bus.phy_abort_o), (c == 15) ? 32'h1 : 32'h0);
      chk($sformatf("t4 phy_valid c%0d", c), 32'(bus.phy_valid_o), (c == 0) ? 32'h1 : 32'h0);
      tick();
      bus.phy_ready_i = 1'b0;
    end
    #1;
    chk("t4 rsp_valid", 32'(bus.rsp_valid_o), 32'h2);
    chk("t4 rsp_err", 32'(bus.rsp_err_o), 32'h1);
    chk("t4 rsp_rdata", bus.rsp_rdata_o, 32'h0);
    tick();
    chk("t4 abort pulse", 32'(bus.phy_abort_o), 32'h0);
    chk("t4 err hold", 32'(bus.rsp_err_o), 32'h1);
    tick();

    // Next requester served; done on the last allowed cycle wins over timeout
    expect_grant("t5 grant", 3'b001);
    tick();
    bus.req_valid_i = 3'b000;
    bus.phy_ready_i = 1'b1;
    for (int c = 0; c < 15; c++) begin
      #1;
      chk($sformatf("t5 abort c%0d", c), 32'(bus.phy_abort_o), 32'h0);
      tick();
      bus.phy_ready_i = 1'b0;
    end
    bus.phy_done_i  = 1'b1;
    bus.phy_rdata_i = 32'h600DF00D;
    #1;
    chk("t5 abort c15", 32'(bus.phy_abort_o), 32'h0);
    tick();
    bus.phy_done_i  = 1'b0;
    #1;
    chk("t5 rsp_valid", 32'(bus.rsp_valid_o), 32'h1);
    chk("t5 rsp_err", 32'(bus.rsp_err_o), 32'h0);
    chk("t5 rsp_rdata", bus.rsp_rdata_o, 32'h600DF00D);
    tick();
    tick();

    // Reset during WAIT
    bus.req_valid_i = 3'b010;
    expect_grant("t6 grant", 3'b010);
    tick();
    bus.req_valid_i = 3'b000;
    bus.phy_ready_i = 1'b1;
    tick();
    bus.phy_ready_i = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    chk("t6 rst ready", 32'(bus.req_ready_o), 32'h0);
    chk("t6 rst phy_valid", 32'(bus.phy_valid_o), 32'h0);
    chk("t6 rst abort", 32'(bus.phy_abort_o), 32'h0);
    chk("t6 rst rsp_valid", 32'(bus.rsp_valid_o), 32'h0);
    chk("t6 rst rsp_rdata", bus.rsp_rdata_o, 32'h0);
    chk("t6 rst phy_cs", 32'(bus.phy_cs_o), 32'h0);
    chk("t6 rst phy_addr", 32'(bus.phy_addr_o), 32'h0);
    chk("t6 rst phy_we", 32'(bus.phy_we_o), 32'h0);
    chk("t6 rst phy_wdata", bus.phy_wdata_o, 32'h0);
    tick();
    tick();
    rst = 1'b0;
    bus.phy_done_i  = 1'b1;
    bus.phy_rdata_i = 32'hFFFFFFFF;
    tick();
    bus.phy_done_i  = 1'b0;
    #1;
    chk("t6 stale done", 32'(bus.rsp_valid_o), 32'h0);
    bus.req_valid_i = 3'b100;
    #1;
    chk("t6 req2 alone", 32'(bus.req_ready_o), 32'h4);
    bus.req_valid_i = 3'b101;
    #1;
    chk("t6 pointer zero", 32'(bus.req_ready_o), 32'h1);
    tick();
    bus.req_valid_i = 3'b000;
    bus.phy_ready_i = 1'b1;
    #1;
    chk("t6 phy_cs", 32'(bus.phy_cs_o), 32'h1);
    tick();
    bus.phy_ready_i = 1'b0;
    bus.phy_done_i  = 1'b1;
    bus.phy_rdata_i = 32'h12345678;
    tick();
    bus.phy_done_i  = 1'b0;
    #1;
    chk("t6 rsp_valid", 32'(bus.rsp_valid_o), 32'h1);
    chk("t6 rsp_rdata", bus.rsp_rdata_o, 32'h12345678);
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
